proc_subword_unpack: RTL and testbench
======================================

PROC_SUBWORD_UNPACK -- requirements
Module: proc_SubwordUnpack

Interface
REQ-001 The block SHALL have one parameter: p_nbits, default 32, word width (only 32 is supported).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req_val  input  1  request valid.
REQ-006 Port: req_rdy  output  1  request ready.
REQ-007 Port: req_data  input  32  packed subword word; lane 0 = bits [7:0] or [15:0].
REQ-008 Port: req_mode  input  2  00 = 8-bit zero-extend; 01 = 8-bit sign-extend; 10 = 16-bit zero-extend; 11 = 16-bit sign-extend.
REQ-009 Port: resp_val  output  1  response valid.
REQ-010 Port: resp_rdy  input  1  response ready.
REQ-011 Port: resp_msg  output  32  extended lane value.
REQ-012 Port: resp_last  output  1  high when resp_msg is the final lane of the word.

Function
REQ-013 A transfer SHALL occur on a rising edge where val and rdy are both high; nothing else transfers.
REQ-014 The FSM SHALL have two states: IDLE and EMIT.
REQ-015 In IDLE, req_rdy = 1 and resp_val = 0.
REQ-016 In EMIT, req_rdy = 0 and resp_val = 1.
REQ-017 A request transfer in IDLE SHALL latch req_data and req_mode, clear the lane index to 0, and enter EMIT.
  - Latency: the first resp_val is asserted in the cycle after the accept.
REQ-018 resp_msg SHALL be lane[idx] of the latched word, zero- or sign-extended to 32 bits per the latched mode.
  - 8-bit lanes: bits [8*idx+7 : 8*idx].
  - 16-bit lanes: bits [16*idx+15 : 16*idx].
REQ-019 The last lane index SHALL be 3 in 8-bit modes and 1 in 16-bit modes; resp_last = 1 only when idx equals it.
REQ-020 On a response transfer with resp_last = 0, idx SHALL increment by 1.
REQ-021 On a response transfer with resp_last = 1, the FSM SHALL return to IDLE.
REQ-022 While resp_val = 1 and resp_rdy = 0, resp_msg, resp_last and idx SHALL hold stable; no lane may be skipped or repeated.
REQ-023 A new request SHALL NOT be accepted in the cycle of the last lane transfer.
  - Steady-state throughput: 5 cycles per 8-bit word, 3 cycles per 16-bit word.
REQ-024 Changes on req_data or req_mode after the accept SHALL NOT affect the output.
REQ-025 No combinational path SHALL exist from resp_rdy or req_val to req_rdy or resp_val.

Reset
REQ-026 Asserting reset (low) SHALL immediately, without waiting for a clock edge, force:
  - state = IDLE, idx = 0, latched data and mode = 0;
  - resp_val = 0, req_rdy = 0, resp_last = 0, resp_msg = 0.
REQ-027 From the first cycle after reset deasserts, req_rdy SHALL be 1.
REQ-028 Reset during EMIT SHALL discard the pending word; the next accepted request SHALL start at lane 0.

Structure
REQ-029 A shared package proc_SubwordPkg SHALL hold:
  - the 2-bit mode enum (U8, S8, U16, S16);
  - the last-lane constants (3, 1);
  - the FSM state typedef.
REQ-030 One combinational sub-module, proc_SubwordLaneExt, SHALL perform lane select and extension (inputs: word, mode, idx; output: 32-bit value).
  - The top level contains only the FSM, index counter and data registers.

Verification
REQ-031 Mode 00, data 0x80FF017F, resp_rdy = 1 -> 0x0000007F, 0x00000001, 0x000000FF, 0x00000080 on consecutive cycles; resp_last high on the 4th only.
REQ-032 Mode 01, data 0x80FF017F -> 0x0000007F, 0x00000001, 0xFFFFFFFF, 0xFFFFFF80.
REQ-033 Mode 11, data 0x80007FFF -> 0x00007FFF, then 0xFFFF8000 with resp_last = 1; mode 10 on the same data -> 0x00007FFF, 0x00008000.
REQ-034 Backpressure: resp_rdy low for 3 cycles on lane 1 (mode 00) -> 0x00000001 held for 4 cycles, then lanes 2 and 3 follow; req_rdy stays 0 throughout.
REQ-035 Reset pulsed low after the lane 1 transfer -> resp_val drops in the same cycle; a following mode 00 request with 0x04030201 yields 0x01, 0x02, 0x03, 0x04.
REQ-036 req_val held high with two mode 00 words -> second accept occurs 5 cycles after the first; 8 responses total, resp_last high exactly twice.

Source files
------------

// File: rtl/proc_subword_unpack_pkg.sv
// Shared types and constants for the subword unpacker: lane modes,
// last-lane indices and the FSM state encoding.
package proc_subword_unpack_pkg;

  localparam int unsigned NBITS = 32;

  typedef enum logic [1:0] {
    MODE_U8  = 2'b00,
    MODE_S8  = 2'b01,
    MODE_U16 = 2'b10,
    MODE_S16 = 2'b11
  } sub_mode_e;

  localparam logic [1:0] LAST_LANE_8  = 2'd3;
  localparam logic [1:0] LAST_LANE_16 = 2'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fsm_state_e;

  // Mode bit 1 selects 16-bit lanes, which leaves only two lanes per word.
  function automatic logic [1:0] last_lane(input sub_mode_e mode);
    return mode[1] ? LAST_LANE_16 : LAST_LANE_8;
  endfunction

endpackage

// File: rtl/proc_subword_unpack_lane_ext.sv
// Combinational lane select plus zero/sign extension of one 8- or 16-bit
// lane out of a packed 32-bit word.
module proc_subword_unpack_lane_ext
  import proc_subword_unpack_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] word,
  input  sub_mode_e          mode,
  input  logic [1:0]         idx,
  output logic [p_nbits-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{idx, 3'b000} +: 8];
    half_lane = word[{idx[0], 4'b0000} +: 16];
    value     = '0;
    unique case (mode)
      MODE_U8:  value = {{(p_nbits-8){1'b0}}, byte_lane};
      MODE_S8:  value = {{(p_nbits-8){byte_lane[7]}}, byte_lane};
      MODE_U16: value = {{(p_nbits-16){1'b0}}, half_lane};
      MODE_S16: value = {{(p_nbits-16){half_lane[15]}}, half_lane};
      default:  value = '0;
    endcase
  end

endmodule

// File: rtl/proc_subword_unpack.sv
// Unpacks one accepted 32-bit word into a stream of extended lanes, lane 0
// first, with resp_last flagging the final lane.
module proc_subword_unpack
  import proc_subword_unpack_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_data,
  input  logic [1:0]         req_mode,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg,
  output logic               resp_last,
  output fsm_state_e         state_dbg
);

  // Handshake: a beat moves on a rising edge only when val and rdy are both
  // high; req_rdy and resp_val are flops so neither depends on the other side.
  fsm_state_e         state;
  logic [1:0]         idx;
  logic [p_nbits-1:0] data_q;
  sub_mode_e          mode_q;
  logic               req_rdy_q;
  logic               resp_val_q;
  logic [p_nbits-1:0] lane_value;
  logic               is_last;

  proc_subword_unpack_lane_ext #(.p_nbits(p_nbits)) u_lane_ext (
    .word  (data_q),
    .mode  (mode_q),
    .idx   (idx),
    .value (lane_value)
  );

  assign is_last   = (idx == last_lane(mode_q));
  assign req_rdy   = req_rdy_q;
  assign resp_val  = resp_val_q;
  assign resp_msg  = lane_value;
  assign resp_last = resp_val_q & is_last;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      data_q     <= '0;
      mode_q     <= MODE_U8;
      req_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_rdy_q is low only in the first cycle out of reset
          req_rdy_q <= 1'b1;
          if (req_val && req_rdy_q) begin
            data_q     <= req_data;
            mode_q     <= sub_mode_e'(req_mode);
            idx        <= 2'd0;
            state      <= ST_EMIT;
            req_rdy_q  <= 1'b0;
            resp_val_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (resp_rdy) begin
            if (is_last) begin
              state      <= ST_IDLE;
              resp_val_q <= 1'b0;
              req_rdy_q  <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_val_q <= 1'b0;
          req_rdy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_subword_unpack.sv
// Bench for proc_subword_unpack: directed lane sequences, backpressure,
// reset mid-word, back-to-back throughput and randomized traffic.
module tb_proc_subword_unpack;
  import proc_subword_unpack_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_data;
  logic [1:0]  req_mode;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;
  logic        resp_last;
  fsm_state_e  state_dbg;

  int checks = 0;
  int errors = 0;

  // {last, msg} per expected response, in order
  logic [32:0] exp_q[$];
  int          accept_cyc[$];
  int          cyc = 0;
  int          resp_count = 0;
  int          last_count = 0;

  int   bp_mode = 0;  // 0: always ready, 1: random, 2: manual
  logic manual_rdy;
  logic rand_rdy = 1'b1;

  assign resp_rdy = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? rand_rdy : manual_rdy;

  proc_subword_unpack #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .resp_last (resp_last),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: split the word into lanes with shifts and masks, extend by sign bit.
  function automatic void model_push(input logic [31:0] w, input logic [1:0] m);
    int unsigned bits;
    int unsigned n;
    logic [31:0] mask;
    logic [31:0] v;
    bits = m[1] ? 16 : 8;
    n    = 32 / bits;
    mask = (bits == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
    for (int unsigned i = 0; i < n; i++) begin
      v = (w >> (bits * i)) & mask;
      if (m[0] && (((v >> (bits - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
      exp_q.push_back({(i == n - 1), v});
    end
  endfunction

  function automatic void push_exp(input logic [31:0] msg, input logic last);
    exp_q.push_back({last, msg});
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic drive_word(input logic [31:0] data, input logic [1:0] mode,
                            input bit hold, input bit use_model);
    bit accepted;
    accepted = 1'b0;
    if (use_model) model_push(data, mode);
    req_val  = 1'b1;
    req_data = data;
    req_mode = mode;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (req_rdy) accepted = 1'b1;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_data = $urandom;
    req_mode = 2'($urandom_range(0, 3));
    if (!hold) req_val = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_val) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / protocol monitor
  logic        prev_stall = 1'b0;
  logic        prev_acc   = 1'b0;
  logic [31:0] prev_msg   = '0;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (!reset) begin
      prev_stall = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      check("rdy_val_excl", 32'(req_rdy & resp_val), 32'd0);
      if (prev_acc) check("first_latency", 32'(resp_val), 32'd1);
      if (prev_stall) begin
        check("hold_val", 32'(resp_val), 32'd1);
        check("hold_msg", resp_msg, prev_msg);
        check("hold_last", 32'(resp_last), 32'(prev_last));
      end
      if (resp_val && resp_rdy) begin
        resp_count++;
        if (resp_last) last_count++;
        if (exp_q.size() == 0) begin
          check("spurious_resp", resp_msg, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("resp_msg", resp_msg, e[31:0]);
          check("resp_last", 32'(resp_last), 32'(e[32]));
        end
      end
      if (req_val && req_rdy) accept_cyc.push_back(cyc);
      prev_stall = resp_val && !resp_rdy;
      prev_acc   = req_val && req_rdy;
      prev_msg   = resp_msg;
      prev_last  = resp_last;
    end
  end

  initial begin
    int a0;
    int r0;
    int l0;
    reset      = 1'b0;
    req_val    = 1'b0;
    req_data   = '0;
    req_mode   = 2'b00;
    manual_rdy = 1'b1;

    #2;
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_resp_msg", resp_msg, 32'd0);
    check("rst_resp_last", 32'(resp_last), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_reset", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;

    // mode 00 / 01 / 11 / 10 directed words
    push_exp(32'h0000_007F, 1'b0); push_exp(32'h0000_0001, 1'b0);
    push_exp(32'h0000_00FF, 1'b0); push_exp(32'h0000_0080, 1'b1);
    drive_word(32'h80FF_017F, 2'b00, 1'b0, 1'b0);
    wait_idle();
    push_exp(32'h0000_007F, 1'b0); push_exp(32'h0000_0001, 1'b0);
    push_exp(32'hFFFF_FFFF, 1'b0); push_exp(32'hFFFF_FF80, 1'b1);
    drive_word(32'h80FF_017F, 2'b01, 1'b0, 1'b0);
    wait_idle();
    push_exp(32'h0000_7FFF, 1'b0); push_exp(32'hFFFF_8000, 1'b1);
    drive_word(32'h8000_7FFF, 2'b11, 1'b0, 1'b0);
    wait_idle();
    push_exp(32'h0000_7FFF, 1'b0); push_exp(32'h0000_8000, 1'b1);
    drive_word(32'h8000_7FFF, 2'b10, 1'b0, 1'b0);
    wait_idle();

    // backpressure on lane 1
    bp_mode    = 2;
    manual_rdy = 1'b0;
    push_exp(32'h0000_007F, 1'b0); push_exp(32'h0000_0001, 1'b0);
    push_exp(32'h0000_00FF, 1'b0); push_exp(32'h0000_0080, 1'b1);
    drive_word(32'h80FF_017F, 2'b00, 1'b0, 1'b0);
    manual_rdy = 1'b1;
    @(posedge clk);
    #1 manual_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_msg", resp_msg, 32'h0000_0001);
      check("bp_req_rdy", 32'(req_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    manual_rdy = 1'b1;
    @(negedge clk);
    check("bp_msg_release", resp_msg, 32'h0000_0001);
    wait_idle();

    // reset after lane 1 transfer
    push_exp(32'h0000_007F, 1'b0); push_exp(32'h0000_0001, 1'b0);
    push_exp(32'h0000_00FF, 1'b0); push_exp(32'h0000_0080, 1'b1);
    drive_word(32'h80FF_017F, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_resp_val", 32'(resp_val), 32'd0);
    check("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
    check("mid_rst_msg", resp_msg, 32'd0);
    check("mid_rst_last", 32'(resp_last), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_mid_rst", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;
    push_exp(32'h0000_0001, 1'b0); push_exp(32'h0000_0002, 1'b0);
    push_exp(32'h0000_0003, 1'b0); push_exp(32'h0000_0004, 1'b1);
    drive_word(32'h0403_0201, 2'b00, 1'b0, 1'b0);
    wait_idle();

    // back-to-back throughput
    bp_mode = 0;
    a0 = accept_cyc.size();
    r0 = resp_count;
    l0 = last_count;
    drive_word($urandom, 2'b00, 1'b1, 1'b1);
    drive_word($urandom, 2'b00, 1'b0, 1'b1);
    wait_idle();
    if (accept_cyc.size() >= a0 + 2)
      check("accept_gap", 32'(accept_cyc[a0+1] - accept_cyc[a0]), 32'd5);
    else
      check("accept_count", 32'(accept_cyc.size() - a0), 32'd2);
    check("b2b_resp_count", 32'(resp_count - r0), 32'd8);
    check("b2b_last_count", 32'(last_count - l0), 32'd2);

    // randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      drive_word($urandom, 2'($urandom_range(0, 3)),
                 (i != 39) && ($urandom_range(0, 1) == 1), 1'b1);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
